alu_mc: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle datapath ALU.
- Adds WIDTH generalisation, valid/ready handshakes on input and output, and iterative unsigned MUL and UDIV alongside the existing ADD/SUB/AND/ORR/EOR set.
- Flags are produced as {N,Z,C,V}.
- Sits between decode/register-read and writeback in the planned multi-cycle core; the control FSM stalls on in_ready / out_valid.

---
 rtl/alu_mc_pkg.sv | 32 +++
 rtl/alu_mc_iter.sv | 97 +++++++++
 rtl/alu_mc.sv | 173 +++++++++++++++++
 tb/tb_alu_mc.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mc_pkg.sv
// Shared opcodes, FSM state, iterator mode and flag layout for the alu_mc
// multi-cycle ALU and its iterative mul/div datapath.
package alu_mc_pkg;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_ORR  = 4'b0011;
   localparam logic [3:0] OP_EOR  = 4'b0110;
   localparam logic [3:0] OP_MUL  = 4'b1000;
   localparam logic [3:0] OP_UDIV = 4'b1001;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
   typedef enum logic {MODE_MUL, MODE_DIV} iter_mode_e;

   function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                             input logic c, input logic v);
      logic [3:0] f;
      f         = '0;
      f[FLAG_N] = n;
      f[FLAG_Z] = z;
      f[FLAG_C] = c;
      f[FLAG_V] = v;
      return f;
   endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// Iterative datapath: one shift-add (MUL) or restoring subtract-shift (UDIV) step
// per enabled cycle. The multiplier is only built when ALU_MC_MUL_EN is defined.
module alu_mc_iter
   import alu_mc_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start_i,
   input  iter_mode_e       mode_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             step_i,
   output logic [WIDTH-1:0] res_o,
   output logic             last_o
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   // acc: product (MUL) or partial remainder (UDIV)
   // opa: shifting multiplicand (MUL) or dividend/quotient (UDIV)
   // opb: shifting multiplier (MUL) or fixed divisor (UDIV)
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   iter_mode_e       mode_q, mode_d;

   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] rem_next;
   logic [WIDTH-1:0] quo_next;
   logic [WIDTH-1:0] prod_next;

   // A zero divisor never borrows, so the quotient naturally comes out all ones.
   always_comb begin
      rem_sh   = {acc_q, opa_q[WIDTH-1]};
      diff     = rem_sh - {1'b0, opb_q};
      rem_next = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
      quo_next = {opa_q[WIDTH-2:0], ~diff[WIDTH]};
   end

`ifdef ALU_MC_MUL_EN
   assign prod_next = opb_q[0] ? (acc_q + opa_q) : acc_q;
`else
   assign prod_next = '0;
`endif

   // NOTE: every next-state signal gets its hold value first, so no latch is inferred.
   always_comb begin
      acc_d  = acc_q;
      opa_d  = opa_q;
      opb_d  = opb_q;
      cnt_d  = cnt_q;
      mode_d = mode_q;
      if (start_i) begin
         mode_d = mode_i;
         cnt_d  = CNT_W'(WIDTH);
         acc_d  = '0;
         opa_d  = a_i;
         opb_d  = b_i;
      end else if (step_i) begin
         cnt_d = cnt_q - CNT_W'(1);
         if (mode_q == MODE_DIV) begin
            acc_d = rem_next;
            opa_d = quo_next;
         end else begin
            acc_d = prod_next;
            opa_d = opa_q << 1;
            opb_d = opb_q >> 1;
         end
      end
   end

   // NOTE: state updates use non-blocking assignment so all registers sample together.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q  <= '0;
         opa_q  <= '0;
         opb_q  <= '0;
         cnt_q  <= '0;
         mode_q <= MODE_MUL;
      end else begin
         acc_q  <= acc_d;
         opa_q  <= opa_d;
         opb_q  <= opb_d;
         cnt_q  <= cnt_d;
         mode_q <= mode_d;
      end
   end

   // Result of the step being taken this cycle; the top captures it on the last one.
   assign res_o  = (mode_q == MODE_DIV) ? quo_next : prod_next;
   assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes: single-cycle ADD/SUB/logic ops plus
// iterative UDIV, and MUL when ALU_MC_MUL_EN is defined (otherwise 1000 is illegal).
module alu_mc
   import alu_mc_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags,
   output logic             div0,
   output logic             illegal
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [3:0]       flags_q, flags_d;
   logic             div0_q, div0_d;
   logic             illegal_q, illegal_d;
   logic             div0_pend_q, div0_pend_d;

   logic             accept;
   logic             is_iter;
   iter_mode_e       iter_mode;
   logic [WIDTH-1:0] iter_res;
   logic             iter_last;
   logic             iter_step;

   logic             sub;
   logic [WIDTH-1:0] b_x;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] sc_res;
   logic             sc_c;
   logic             sc_v;
   logic             sc_ill;

   always_comb begin
      is_iter   = 1'b0;
      iter_mode = MODE_DIV;
      if (op == OP_UDIV) is_iter = 1'b1;
`ifdef ALU_MC_MUL_EN
      if (op == OP_MUL) begin
         is_iter   = 1'b1;
         iter_mode = MODE_MUL;
      end
`endif
   end

   // Single-cycle ops; MUL/UDIV codes land in default but are steered away by is_iter.
   always_comb begin
      sub    = (op == OP_SUB);
      b_x    = sub ? ~b : b;
      sum    = {1'b0, a} + {1'b0, b_x} + {{WIDTH{1'b0}}, sub};
      sc_res = '0;
      sc_c   = 1'b0;
      sc_v   = 1'b0;
      sc_ill = 1'b0;
      case (op)
         OP_ADD, OP_SUB: begin
            sc_res = sum[WIDTH-1:0];
            sc_c   = sum[WIDTH];
            sc_v   = ~(a[WIDTH-1] ^ b[WIDTH-1] ^ sub) & (a[WIDTH-1] ^ sum[WIDTH-1]);
         end
         OP_AND:  sc_res = a & b;
         OP_ORR:  sc_res = a | b;
         OP_EOR:  sc_res = a ^ b;
         default: sc_ill = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = is_iter ? BUSY : DONE;
         BUSY:    if (iter_last) state_d = DONE;
         DONE: begin
            if (out_ready) begin
               if (in_valid) state_d = is_iter ? BUSY : DONE;
               else          state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: in_ready = 1'b1;
         DONE: begin
            in_ready  = out_ready;
            out_valid = 1'b1;
         end
         default: ;
      endcase
   end

   assign accept    = in_valid & in_ready;
   assign iter_step = (state_q == BUSY);

   alu_mc_iter #(.WIDTH(WIDTH)) u_iter (
      .clk     (clk),
      .reset_n (reset_n),
      .start_i (accept & is_iter),
      .mode_i  (iter_mode),
      .a_i     (a),
      .b_i     (b),
      .step_i  (iter_step),
      .res_o   (iter_res),
      .last_o  (iter_last)
   );

   // Outputs only change on a fresh single-cycle accept or the final iteration,
   // which keeps them stable while the consumer stalls.
   always_comb begin
      result_d    = result_q;
      flags_d     = flags_q;
      div0_d      = div0_q;
      illegal_d   = illegal_q;
      div0_pend_d = div0_pend_q;
      if (accept) begin
         if (is_iter) begin
            div0_pend_d = (iter_mode == MODE_DIV) && (b == '0);
         end else begin
            result_d  = sc_res;
            flags_d   = pack_flags(sc_res[WIDTH-1], sc_res == '0, sc_c, sc_v);
            div0_d    = 1'b0;
            illegal_d = sc_ill;
         end
      end else if (iter_step && iter_last) begin
         result_d  = iter_res;
         flags_d   = pack_flags(iter_res[WIDTH-1], iter_res == '0, 1'b0, 1'b0);
         div0_d    = div0_pend_q;
         illegal_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         result_q    <= '0;
         flags_q     <= '0;
         div0_q      <= 1'b0;
         illegal_q   <= 1'b0;
         div0_pend_q <= 1'b0;
      end else begin
         result_q    <= result_d;
         flags_q     <= flags_d;
         div0_q      <= div0_d;
         illegal_q   <= illegal_d;
         div0_pend_q <= div0_pend_d;
      end
   end

   assign result  = result_q;
   assign flags   = flags_q;
   assign div0    = div0_q;
   assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: driver pushes model expectations on accept, a monitor
// pops and compares when out_valid rises and re-checks stability while stalled.
module tb_alu_mc;

   localparam int W = 32;
   localparam logic [W-1:0] ONES = '1;
   localparam longint SMAX = (longint'(1) <<< (W-1)) - 1;
   localparam longint SMIN = -(longint'(1) <<< (W-1));

   typedef struct {
      logic [W-1:0] res;
      logic [3:0]   flg;
      logic         d0;
      logic         ill;
      int           lat;
      int           acc_cyc;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [3:0]   op = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] result;
   logic [3:0]   flags;
   logic         div0;
   logic         illegal;

   exp_t sb[$];
   exp_t cur;
   bit   seen = 1'b0;
   bit   cur_ok = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   rdy_mode = 0;

   alu_mc #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags),
      .div0      (div0),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model from the arithmetic rules, using wide integer math.
   function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t e;
      longint unsigned u;
      longint s;
      logic c, v;
      c = 1'b0; v = 1'b0;
      e.res = '0; e.d0 = 1'b0; e.ill = 1'b0; e.lat = 1; e.acc_cyc = 0;
      case (o)
         4'b0000: begin
            u = longint'(x) + longint'(y);
            e.res = u[W-1:0]; c = u[W];
            s = longint'($signed(x)) + longint'($signed(y));
            v = (s > SMAX) || (s < SMIN);
         end
         4'b0001: begin
            e.res = x - y; c = (x >= y);
            s = longint'($signed(x)) - longint'($signed(y));
            v = (s > SMAX) || (s < SMIN);
         end
         4'b0010: e.res = x & y;
         4'b0011: e.res = x | y;
         4'b0110: e.res = x ^ y;
`ifdef ALU_MC_MUL_EN
         4'b1000: begin
            u = longint'(x) * longint'(y);
            e.res = u[W-1:0]; e.lat = W + 1;
         end
`endif
         4'b1001: begin
            e.lat = W + 1;
            if (y == '0) begin e.res = ONES; e.d0 = 1'b1; end
            else e.res = x / y;
         end
         default: e.ill = 1'b1;
      endcase
      e.flg = {e.res[W-1], e.res == '0, c, v};
      return e;
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return ONES;
         2:       return {1'b1, {(W-1){1'b0}}};
         3:       return W'($urandom_range(0, 15));
         default: return W'($urandom);
      endcase
   endfunction

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      bit   done = 1'b0;
      exp_t e;
      in_valid = 1'b1; op = o; a = x; b = y;
      for (int n = 0; n < 200 && !done; n++) begin
         @(negedge clk);
         if (in_ready) begin
            e = model(o, x, y);
            e.acc_cyc = cyc;
            sb.push_back(e);
            done = 1'b1;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0; op = 4'($urandom); a = W'($urandom); b = W'($urandom);
      if (!done) begin
         checks++; errors++;
         $display("FAIL accept_timeout: op %0h not accepted", o);
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || seen) && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (sb.size() != 0 || seen) begin
         errors++;
         $display("FAIL drain_timeout: %0d results outstanding", sb.size());
      end
   endtask

   initial forever begin
      @(posedge clk); #1;
      case (rdy_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = ($urandom_range(0, 3) != 0);
         default: out_ready = 1'b0;
      endcase
   end

   initial forever begin
      @(negedge clk);
      if (!reset_n) begin
         seen = 1'b0;
      end else if (out_valid) begin
         if (!seen) begin
            seen = 1'b1;
            if (sb.size() == 0) begin
               cur_ok = 1'b0;
               checks++; errors++;
               $display("FAIL spurious_out: out_valid with nothing issued, result %0h", result);
            end else begin
               cur = sb.pop_front();
               cur_ok = 1'b1;
               check("latency", 64'(cyc - cur.acc_cyc), 64'(cur.lat));
            end
         end
         if (cur_ok) begin
            check("result", 64'(result), 64'(cur.res));
            check("flags", 64'(flags), 64'(cur.flg));
            check("div0", 64'(div0), 64'(cur.d0));
            check("illegal", 64'(illegal), 64'(cur.ill));
         end
         check("in_ready_done", 64'(in_ready), 64'(out_ready));
         if (out_ready) seen = 1'b0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_result", 64'(result), 64'd0);
      check("rst_flags", 64'(flags), 64'd0);
      check("rst_div0_ill", 64'({div0, illegal}), 64'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;

      issue(4'b0000, 32'h7FFF_FFFF, 32'h1);
      issue(4'b0001, 32'd5, 32'd5);
      issue(4'b0001, 32'd0, 32'd1);
      issue(4'b1000, 32'h0001_0000, 32'h0001_0001);
      issue(4'b1001, 32'd100, 32'd7);
      issue(4'b1001, 32'd9, 32'd0);
      issue(4'b1111, 32'd3, 32'd4);
      drain();

      // Backpressure: EOR result held for several cycles, then ORR issued as it is consumed.
      rdy_mode = 2;
      issue(4'b0110, 32'hA5A5_0F0F, 32'h0FF0_FFFF);
      repeat (6) begin @(posedge clk); #1; end
      rdy_mode = 0;
      issue(4'b0011, 32'h1234_0000, 32'h0000_5678);
      drain();

      // Reset in the middle of a divide discards it entirely.
      issue(4'b1001, W'($urandom), 32'd3);
      repeat (10) @(posedge clk);
      #2 reset_n = 1'b0;
      sb.delete();
      @(negedge clk);
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_result", 64'(result), 64'd0);
      check("midrst_flags", 64'({flags, div0, illegal}), 64'd0);
      check("midrst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (40) begin @(posedge clk); #1; end
      issue(4'b0000, 32'd2, 32'd3);
      drain();

      // Randomized traffic with random backpressure and issue gaps.
      rdy_mode = 1;
      for (int i = 0; i < 300; i++) begin
         logic [3:0] o;
         case ($urandom_range(0, 8))
            0: o = 4'b0000;
            1: o = 4'b0001;
            2: o = 4'b0010;
            3: o = 4'b0011;
            4: o = 4'b0110;
            5: o = 4'b1000;
            6: o = 4'b1001;
            7: o = 4'b0001;
            default: o = 4'($urandom);
         endcase
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         issue(o, pick(), pick());
      end
      rdy_mode = 0;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
